// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, oversampling constants and vote helper
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} uart_rx_state_t;

  // Ticks per bit; the transmitter derives its bit-end count from this too.
  localparam int OVERSAMPLE = 16;

  // edges_counter values whose ticks capture the three mid-bit samples.
  localparam logic [3:0] SAMPLE_FIRST = 4'd7;
  localparam logic [3:0] SAMPLE_MID   = 4'd8;
  localparam logic [3:0] SAMPLE_LAST  = 4'd9;

  // Counter value of the last tick in a bit period (wraps to 0 after it).
  localparam logic [3:0] EDGE_LAST = 4'(OVERSAMPLE - 1);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - reset-to-one flop chain for an asynchronous input
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the raw input through the chain; reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling and majority vote
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  input  logic       sck_rising_edge,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       frame_error,
  output logic       busy
);

  logic           w_sin_s;
  logic           w_vote_live;
  logic           w_vote;
  uart_rx_state_t r_state;
  logic [3:0]     r_edges;
  logic [2:0]     r_bits;
  logic [7:0]     r_shift;
  logic [7:0]     r_rx_data;
  logic           r_valid;
  logic           r_ferr;
  logic           r_s7;
  logic           r_s8;
  logic           r_s9;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (sin),
    .q  (w_sin_s)
  );

  // At the counter-9 tick the third sample is still on the line, so vote on it
  // directly; at the bit-end tick all three samples are already stored.
  assign w_vote_live = majority3(r_s7, r_s8, w_sin_s);
  assign w_vote      = majority3(r_s7, r_s8, r_s9);

  // Receive FSM, counters, sample capture and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_edges   <= 4'd0;
      r_bits    <= 3'd0;
      r_shift   <= 8'h00;
      r_rx_data <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_s7      <= 1'b1;
      r_s8      <= 1'b1;
      r_s9      <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (sck_rising_edge) begin
        // Counting and sampling only happen while a frame is being timed.
        if (r_state == START || r_state == DATA || r_state == STOP) begin
          r_edges <= r_edges + 4'd1;
          if (r_edges == SAMPLE_FIRST) r_s7 <= w_sin_s;
          if (r_edges == SAMPLE_MID)   r_s8 <= w_sin_s;
          if (r_edges == SAMPLE_LAST)  r_s9 <= w_sin_s;
        end
        case (r_state)
          IDLE: begin
            // The detecting tick itself is not counted.
            if (!w_sin_s) begin
              r_state <= START;
              r_edges <= 4'd0;
            end
          end
          START: begin
            if (r_edges == SAMPLE_LAST && w_vote_live) begin
              // Start bit did not hold through mid-bit: treat as a glitch.
              r_state <= IDLE;
              r_edges <= 4'd0;
            end else if (r_edges == EDGE_LAST) begin
              r_state <= DATA;
              r_bits  <= 3'd0;
            end
          end
          DATA: begin
            if (r_edges == EDGE_LAST) begin
              r_shift <= {w_vote, r_shift[7:1]};
              if (r_bits == 3'd7) begin
                r_state <= STOP;
              end else begin
                r_bits <= r_bits + 3'd1;
              end
            end
          end
          STOP: begin
            // Leave mid stop bit so a following start edge is caught early.
            if (r_edges == SAMPLE_LAST) begin
              r_edges <= 4'd0;
              if (w_vote_live) begin
                r_rx_data <= r_shift;
                r_valid   <= 1'b1;
                r_state   <= IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= RECOVER;
              end
            end
          end
          RECOVER: begin
            // Hold off until the line returns high so a break is one error.
            if (w_sin_s) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_data_valid = r_valid;
  assign frame_error   = r_ferr;
  assign busy          = (r_state != IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive path, the counterpart to the SoC UART transmitter. Format is 8N1, LSB first, 16x oversampling driven by the shared `sck_rising_edge` tick from the UART baud generator.
- Synchronises the asynchronous `sin` line.
- Detects and qualifies the start bit.
- Majority-votes each bit at mid-period.
- Delivers each byte with a one-cycle valid pulse, or flags a framing error.
- Sits beside the transmitter inside the UART peripheral; the register interface consumes `rx_data`/`rx_data_valid`.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the `sin` synchroniser (minimum 2).

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
sin  input  1  asynchronous serial input, idle high
sck_rising_edge  input  1  one-clk oversampling tick, 16 ticks per bit
rx_data  output  8  last correctly received byte
rx_data_valid  output  1  one-clk pulse: new byte on rx_data
frame_error  output  1  one-clk pulse: stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
Clocking and reset:
- Single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state IDLE, edges_counter 0, bits_counter 0, shift register 0x00, rx_data 0x00, rx_data_valid 0, frame_error 0, busy 0.
- Synchroniser flops reset to 1, the idle line level.
- `rst` asserted mid-frame aborts the frame with no output pulses and returns to IDLE.

Synchroniser:
- `sin` passes through SYNC_STAGES flops to give `sin_s`. All logic below uses `sin_s` only.

Counters:
- edges_counter is 4 bits. It advances only on `sck_rising_edge` and wraps 15 -> 0; at that wrap the bit period ends.
- bits_counter is 3 bits.
- Ticks with counter values 7, 8 and 9 capture samples s7, s8, s9. vote = majority(s7, s8, s9).

IDLE:
- On a tick with `sin_s` = 0: go to START with edges_counter = 0.
- The detecting tick is not counted.

START:
- On the tick with counter 9: if vote = 1 (false start / glitch), go to IDLE and clear the counter; no pulse.
- Otherwise, at counter 15: go to DATA with bits_counter = 0.

DATA:
- At counter 15: shift = {vote, shift[7:1]} (LSB first).
- If bits_counter = 7: go to STOP. Otherwise increment bits_counter.

STOP, on the tick with counter 9:
- If vote = 1: rx_data <= shift, rx_data_valid = 1 for exactly one clk in the following cycle, then go to IDLE.
  - The early return (mid stop bit) gives half a bit of resync margin for back-to-back frames.
- If vote = 0: frame_error pulses for one clk, rx_data is unchanged, then go to RECOVER.

RECOVER:
- Wait for a tick with `sin_s` = 1, then go to IDLE.
- This prevents a break condition (line held low) from producing repeated 0x00 frames.

Outputs and timing:
- rx_data_valid and frame_error are registered and mutually exclusive.
- There is no overrun detection: a new byte overwrites rx_data. Consumers must capture rx_data on the valid pulse.
- busy is decoded combinationally from the state register.
- Ticks arriving in consecutive clks are legal; the block must not depend on gaps between ticks.
- Latency is the synchroniser delay plus 9.5 bit periods (nominal), measured from the `sin` falling edge to the valid pulse.

Decomposition:
uart_pkg holds:
- `typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} uart_rx_state_t`
- localparam OVERSAMPLE = 16
- localparams SAMPLE_FIRST = 7, SAMPLE_MID = 8, SAMPLE_LAST = 9
- OVERSAMPLE is shared with the transmitter, replacing its literal 15.

One sub-module: uart_rx_sync. It is the parameterised SYNC_STAGES flop chain with reset value 1, reusable for other asynchronous inputs.

Test Plan:
1. Tick every 4 clk; send 0xA5 as 8N1 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> one rx_data_valid pulse, rx_data = 0xA5, frame_error never asserted, busy = 0 afterwards.
2. `sin` low for 3 ticks, then high -> no valid pulse, no frame_error; busy returns to 0 at the counter-9 tick of START.
3. Send 0x3C with a 1-tick low glitch at counter 8 of bit 2 (value 1) -> majority vote keeps the bit; rx_data = 0x3C.
4. Send 0x55 with the stop bit held low, then `sin` low for 40 more ticks before going high -> single frame_error pulse, rx_data keeps its previous value, busy stays high until `sin` rises, no further pulses.
5. Back-to-back 0x00, 0xFF, 0x81 with no idle gap, ticks on consecutive clks -> three valid pulses in order with matching rx_data.
6. Assert `rst` for 1 clk during DATA bit 4 of 0xF0, then send 0x0F -> no pulse for the aborted frame; all outputs at reset values the cycle after reset; rx_data = 0x0F after the second frame.
